// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the bitcoin hash engine and its downstream scan logic.
// Pure declarations: no latency, no flow control.
package bitcoin_pkg;

    localparam int NUM_NONCES_DFLT = 16;

    typedef logic [31:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // SHA-256 initial hash values, kept here so the hash engine and its consumers agree.
    localparam word_t SHA256_H0 = 32'h6a09e667;
    localparam word_t SHA256_H1 = 32'hbb67ae85;
    localparam word_t SHA256_H2 = 32'h3c6ef372;
    localparam word_t SHA256_H3 = 32'ha54ff53a;
    localparam word_t SHA256_H4 = 32'h510e527f;
    localparam word_t SHA256_H5 = 32'h9b05688c;
    localparam word_t SHA256_H6 = 32'h1f83d9ab;
    localparam word_t SHA256_H7 = 32'h5be0cd19;

endpackage

// File: rtl/nonce_target_scan_if.sv
// Shared single-port memory bus between the hash engine memory and its clients.
// Synchronous read: read data is valid one cycle after the address; no backpressure.
interface nonce_target_scan_if;
    import bitcoin_pkg::*;

    logic  mem_clk;
    logic  mem_we;
    addr_t mem_addr;
    word_t mem_write_data;
    word_t mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/nonce_target_scan_hash_word_cmp.sv
// Combinational hash-word comparator: new-minimum decision (ties keep lower index) and target test.
// Zero latency, no flow control.
module hash_word_cmp
    import bitcoin_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  word_t             candidate,
    input  word_t             best,
    input  word_t             target,
    input  logic [IDX_W-1:0]  idx,
    input  logic [IDX_W-1:0]  best_idx,
    output logic              take_new,
    output logic              below_target
);

    always_comb begin
        take_new     = (candidate < best) || ((candidate == best) && (idx < best_idx));
        below_target = (candidate < target);
    end

endmodule

// File: rtl/nonce_target_scan.sv
// Scans NUM_NONCES hash words from memory for the lowest-index minimum and tests it against a target.
// done rises NUM_NONCES+2 edges after start (earlier with NONCE_SCAN_EARLY_EXIT_EN); read-only, never stalls.
module nonce_target_scan
    import bitcoin_pkg::*;
#(
    parameter  int NUM_NONCES = NUM_NONCES_DFLT,
    localparam int IDX_W      = $clog2(NUM_NONCES)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  addr_t                       hash_addr,
    input  word_t                       target,
    nonce_target_scan_if.master         mem,
    output logic                        done,
    output logic                        found,
    output logic [IDX_W-1:0]            best_nonce,
    output word_t                       best_hash
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

    scan_state_t      state;
    word_t            target_q;
    logic [IDX_W-1:0] rd_idx;
    logic             take_new;
    logic             below_target;

    assign mem.mem_clk        = clk;
    assign mem.mem_we         = 1'b0;
    assign mem.mem_write_data = '0;

    hash_word_cmp #(.IDX_W(IDX_W)) u_cmp (
        .candidate    (mem.mem_read_data),
        .best         (best_hash),
        .target       (target_q),
        .idx          (rd_idx),
        .best_idx     (best_nonce),
        .take_new     (take_new),
        .below_target (below_target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mem.mem_addr <= '0;
            target_q     <= '0;
            rd_idx       <= '0;
            done         <= 1'b0;
            found        <= 1'b0;
            best_nonce   <= '0;
            best_hash    <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target_q     <= target;
                        mem.mem_addr <= hash_addr;
                        done         <= 1'b0;
                        found        <= 1'b0;
                        best_hash    <= '1;
                        best_nonce   <= '0;
                        rd_idx       <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem.mem_addr <= mem.mem_addr + 16'd1;
                    state        <= SCAN;
                end
                SCAN: begin
                    // Addresses keep streaming one ahead of the data; the final extra read is discarded.
                    mem.mem_addr <= mem.mem_addr + 16'd1;
                    rd_idx       <= rd_idx + IDX_W'(1);
                    if (take_new) begin
                        best_hash  <= mem.mem_read_data;
                        best_nonce <= rd_idx;
                    end
                    if (rd_idx == LAST_IDX) begin
                        state <= DONE;
                    end
`ifdef NONCE_SCAN_EARLY_EXIT_EN
                    // Every earlier word was >= target, so a qualifying word is also the minimum so far.
                    if (below_target) begin
                        best_hash  <= mem.mem_read_data;
                        best_nonce <= rd_idx;
                        state      <= DONE;
                    end
`endif
                end
                DONE: begin
                    done  <= 1'b1;
                    found <= (best_hash < target_q);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef NONCE_SCAN_EARLY_EXIT_EN
    logic unused_below_target;
    assign unused_below_target = below_target;
`endif

endmodule

// File: tb/tb_nonce_target_scan.sv
// Directed self-checking bench for nonce_target_scan with a synchronous-read memory model.
module tb_nonce_target_scan;
    import bitcoin_pkg::*;

    localparam int NUM = 16;
    localparam int BOUND = 64;

`ifdef NONCE_SCAN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    addr_t       hash_addr = '0;
    word_t       target = '0;
    logic        done;
    logic        found;
    logic [3:0]  best_nonce;
    word_t       best_hash;

    word_t       mem [0:65535];
    int          n_checks = 0;
    int          n_errors = 0;
    int          we_bad = 0;
    int          lat;

    nonce_target_scan_if mif ();

    nonce_target_scan #(.NUM_NONCES(NUM)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .hash_addr  (hash_addr),
        .target     (target),
        .mem        (mif),
        .done       (done),
        .found      (found),
        .best_nonce (best_nonce),
        .best_hash  (best_hash)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mif.mem_read_data <= mem[mif.mem_addr];

    always @(posedge clk) begin
        if (mif.mem_we !== 1'b0 || mif.mem_write_data !== 32'h0) we_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a scan and counts edges until done; can also check read addresses,
    // poke a stray start mid-scan, or assert reset at a chosen edge.
    task automatic run_scan(input addr_t base, input word_t tgt, input bit chk_addr,
                            input int poke_at, input int rst_at, output int lat_o);
        @(negedge clk);
        hash_addr = base;
        target    = tgt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat_o = 0;
        while (done !== 1'b1 && lat_o < BOUND) begin
            if (chk_addr && lat_o < NUM) check("rd_addr", {16'h0, mif.mem_addr}, {16'h0, 16'(base + lat_o)});
            if (lat_o == poke_at) begin
                start = 1'b1; hash_addr = 16'hFFF8; target = 32'h0;
            end else begin
                start = 1'b0; hash_addr = base; target = tgt;
            end
            if (lat_o == rst_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_done", {31'h0, done}, 32'h0);
                check("rst_found", {31'h0, found}, 32'h0);
                check("rst_best_hash", best_hash, 32'hFFFFFFFF);
                check("rst_best_nonce", {28'h0, best_nonce}, 32'h0);
                check("rst_mem_addr", {16'h0, mif.mem_addr}, 32'h0);
                start = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            lat_o++;
        end
        start = 1'b0;
        if (lat_o >= BOUND) check("done_timeout", lat_o, 32'(NUM + 2));
    endtask

    task automatic expect_result(input string tag, input int exp_lat, input int exp_nonce,
                                 input word_t exp_hash, input bit exp_found);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_nonce"}, {28'h0, best_nonce}, exp_nonce);
        check({tag, "_hash"}, best_hash, exp_hash);
        check({tag, "_found"}, {31'h0, found}, {31'h0, exp_found});
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'hFFFFFFFF;
        for (int i = 0; i < NUM; i++) mem[16'h40 + i] = 32'h1000_0000 + i;

        #12;
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_found", {31'h0, found}, 32'h0);
        check("reset_best_hash", best_hash, 32'hFFFFFFFF);
        check("reset_best_nonce", {28'h0, best_nonce}, 32'h0);
        check("reset_mem_addr", {16'h0, mif.mem_addr}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Ascending words, target equal to the minimum: not strictly below.
        run_scan(16'h0040, 32'h1000_0000, 1'b1, -1, -1, lat);
        expect_result("ascend", NUM + 2, 0, 32'h1000_0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", {31'h0, done}, 32'h1);

        mem[16'h4B] = 32'h0000_00FF;
        run_scan(16'h0040, 32'h0001_0000, 1'b0, -1, -1, lat);
        expect_result("min11", EARLY ? 14 : NUM + 2, 11, 32'h0000_00FF, 1'b1);

        // Stray start with different inputs during SCAN must not disturb the scan.
        run_scan(16'h0040, 32'h0001_0000, 1'b0, 5, -1, lat);
        expect_result("poke", EARLY ? 14 : NUM + 2, 11, 32'h0000_00FF, 1'b1);

        run_scan(16'h0040, 32'h1000_0000, 1'b0, -1, 7, lat);
        @(negedge clk);
        reset_n = 1'b1;
        run_scan(16'h0040, 32'h0001_0000, 1'b0, -1, -1, lat);
        expect_result("post_rst", EARLY ? 14 : NUM + 2, 11, 32'h0000_00FF, 1'b1);

        // Duplicate minimum; target 0 can never be beaten.
        mem[16'h4B] = 32'h1000_000B;
        mem[16'h43] = 32'h0000_0005;
        mem[16'h49] = 32'h0000_0005;
        run_scan(16'h0040, 32'h0000_0000, 1'b0, -1, -1, lat);
        expect_result("tie", NUM + 2, 3, 32'h0000_0005, 1'b0);

        // Base near the top of the address space wraps to 0000.
        for (int i = 0; i < NUM; i++) mem[16'(16'hFFF8 + i)] = 32'h3000_0000 + i;
        mem[16'h0004] = 32'h0000_1234;
        run_scan(16'hFFF8, 32'h0000_0000, 1'b1, -1, -1, lat);
        expect_result("wrap", NUM + 2, 12, 32'h0000_1234, 1'b0);

        // All-ones words with the maximum target: nothing strictly below.
        run_scan(16'h0100, 32'hFFFF_FFFF, 1'b0, -1, -1, lat);
        expect_result("all_ones", NUM + 2, 0, 32'hFFFF_FFFF, 1'b0);

        mem[16'h43] = 32'h1000_0003;
        mem[16'h49] = 32'h1000_0009;
        mem[16'h44] = 32'h0000_0800;
        mem[16'h4A] = 32'h0000_0010;
        run_scan(16'h0040, 32'h0000_1000, 1'b0, -1, -1, lat);
        if (EARLY) expect_result("early", 7, 4, 32'h0000_0800, 1'b1);
        else       expect_result("early", NUM + 2, 10, 32'h0000_0010, 1'b1);

        check("mem_we_quiet", we_bad, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
